// File: rtl/fifoflush_pkt.sv
// FIFO pointer controller with flush, packet commit/discard, thresholds and sticky errors.
// Optional high-water mark tracking is enabled by defining FIFOFLUSH_PKT_HWM_EN.
module fifoflush_pkt #(
   parameter int unsigned ADDR     = 4,
   parameter bit          PKT_MODE = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fifowr,
   input  logic            fiford,
   input  logic            fifoflsh,
   input  logic            wr_commit,
   input  logic            wr_discard,
   input  logic            err_clr,
   input  logic [ADDR:0]   afull_th,
   input  logic [ADDR:0]   aempt_th,
`ifdef FIFOFLUSH_PKT_HWM_EN
   input  logic            hwm_clr,
   output logic [ADDR:0]   hwm,
`endif
   output logic            fifofull,
   output logic            notempty,
   output logic            afull,
   output logic            aempty,
   output logic [ADDR:0]   fifolen,
   output logic [ADDR:0]   rdlen,
   output logic            ovf,
   output logic            udf,
   output logic            mem_wr,
   output logic [ADDR-1:0] mem_wa,
   output logic            mem_rd,
   output logic [ADDR-1:0] mem_ra
);

   localparam int unsigned PW = ADDR + 1;

   logic [ADDR:0] wr_ptr, cm_ptr, rd_ptr;
   logic [ADDR:0] wr_ptr_nxt, cm_ptr_nxt, rd_ptr_nxt;
   logic          discard_act, commit_act;
   logic          ovf_set, udf_set;

   assign discard_act = PKT_MODE & wr_discard;
   assign commit_act  = PKT_MODE & wr_commit;

   assign fifolen  = wr_ptr - rd_ptr;
   assign rdlen    = cm_ptr - rd_ptr;
   assign fifofull = fifolen[ADDR];
   assign notempty = (rdlen != '0);
   assign afull    = (fifolen >= afull_th);
   assign aempty   = (rdlen <= aempt_th);

   assign mem_wr = fifowr & ~fifofull & ~fifoflsh & ~discard_act;
   assign mem_rd = fiford & notempty & ~fifoflsh;
   assign mem_wa = wr_ptr[ADDR-1:0];
   assign mem_ra = rd_ptr[ADDR-1:0];

   assign ovf_set = fifowr & fifofull & ~fifoflsh;
   assign udf_set = fiford & ~notempty & ~fifoflsh;

   // Discard outranks commit; without packet mode the commit pointer shadows the write pointer.
   always_comb begin
      wr_ptr_nxt = wr_ptr + PW'(mem_wr);
      cm_ptr_nxt = cm_ptr;
      rd_ptr_nxt = rd_ptr + PW'(mem_rd);
      if (fifoflsh) begin
         wr_ptr_nxt = '0;
         cm_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else if (!PKT_MODE) begin
         cm_ptr_nxt = wr_ptr + PW'(mem_wr);
      end else if (discard_act) begin
         wr_ptr_nxt = cm_ptr;
      end else if (commit_act) begin
         cm_ptr_nxt = wr_ptr + PW'(mem_wr);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         cm_ptr <= cm_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
      end
   end

   // A same-cycle set takes precedence over err_clr.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (ovf_set)      ovf <= 1'b1;
         else if (err_clr) ovf <= 1'b0;
         if (udf_set)      udf <= 1'b1;
         else if (err_clr) udf <= 1'b0;
      end
   end

`ifdef FIFOFLUSH_PKT_HWM_EN
   logic [ADDR:0] hwm_nxt;

   always_comb begin
      hwm_nxt = hwm;
      if (fifolen > hwm)  hwm_nxt = fifolen;
      else if (hwm_clr)   hwm_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) hwm <= '0;
      else        hwm <= hwm_nxt;
   end
`endif

endmodule

// File: tb/tb_fifoflush_pkt.sv
// Directed self-checking bench for fifoflush_pkt (packet mode plus a non-packet instance).
module tb_fifoflush_pkt;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fifowr, fiford, fifoflsh, wr_commit, wr_discard, err_clr;
   logic [4:0] afull_th, aempt_th;
   logic       fifofull, notempty, afull, aempty, ovf, udf, mem_wr, mem_rd;
   logic [4:0] fifolen, rdlen;
   logic [3:0] mem_wa, mem_ra;
`ifdef FIFOFLUSH_PKT_HWM_EN
   logic       hwm_clr;
   logic [4:0] hwm;
   logic       np_hwm_clr;
   logic [4:0] np_hwm;
`endif

   logic       np_wr, np_rd, np_flsh, np_commit, np_discard, np_err_clr;
   logic [4:0] np_afull_th, np_aempt_th;
   logic       np_full, np_notempty, np_afull, np_aempty, np_ovf, np_udf, np_mem_wr, np_mem_rd;
   logic [4:0] np_fifolen, np_rdlen;
   logic [3:0] np_mem_wa, np_mem_ra;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fifoflush_pkt #(.ADDR(4), .PKT_MODE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .fifowr(fifowr), .fiford(fiford), .fifoflsh(fifoflsh),
      .wr_commit(wr_commit), .wr_discard(wr_discard), .err_clr(err_clr),
      .afull_th(afull_th), .aempt_th(aempt_th),
`ifdef FIFOFLUSH_PKT_HWM_EN
      .hwm_clr(hwm_clr), .hwm(hwm),
`endif
      .fifofull(fifofull), .notempty(notempty), .afull(afull), .aempty(aempty),
      .fifolen(fifolen), .rdlen(rdlen), .ovf(ovf), .udf(udf),
      .mem_wr(mem_wr), .mem_wa(mem_wa), .mem_rd(mem_rd), .mem_ra(mem_ra)
   );

   fifoflush_pkt #(.ADDR(4), .PKT_MODE(1'b0)) u_np (
      .clk(clk), .rst_n(rst_n), .fifowr(np_wr), .fiford(np_rd), .fifoflsh(np_flsh),
      .wr_commit(np_commit), .wr_discard(np_discard), .err_clr(np_err_clr),
      .afull_th(np_afull_th), .aempt_th(np_aempt_th),
`ifdef FIFOFLUSH_PKT_HWM_EN
      .hwm_clr(np_hwm_clr), .hwm(np_hwm),
`endif
      .fifofull(np_full), .notempty(np_notempty), .afull(np_afull), .aempty(np_aempty),
      .fifolen(np_fifolen), .rdlen(np_rdlen), .ovf(np_ovf), .udf(np_udf),
      .mem_wr(np_mem_wr), .mem_wa(np_mem_wa), .mem_rd(np_mem_rd), .mem_ra(np_mem_ra)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      fifowr = 0; fiford = 0; fifoflsh = 0; wr_commit = 0; wr_discard = 0; err_clr = 0;
      np_wr = 0; np_rd = 0; np_flsh = 0; np_commit = 0; np_discard = 0; np_err_clr = 0;
      np_afull_th = 5'd8; np_aempt_th = 5'd1;
`ifdef FIFOFLUSH_PKT_HWM_EN
      hwm_clr = 0; np_hwm_clr = 0;
`endif
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      afull_th = 5'd12; aempt_th = 5'd2;
      do_reset();
      total_cnt++; if (fifofull !== 1'b0) $display("FAIL rst_full got %b exp 0", fifofull); else pass_cnt++;
      total_cnt++; if (notempty !== 1'b0) $display("FAIL rst_notempty got %b exp 0", notempty); else pass_cnt++;
      total_cnt++; if (fifolen !== 5'd0) $display("FAIL rst_fifolen got %0d exp 0", fifolen); else pass_cnt++;
      total_cnt++; if (rdlen !== 5'd0) $display("FAIL rst_rdlen got %0d exp 0", rdlen); else pass_cnt++;
      total_cnt++; if (aempty !== 1'b1 || afull !== 1'b0) $display("FAIL rst_thresh got ae=%b af=%b exp 1 0", aempty, afull); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL rst_err got ovf=%b udf=%b exp 0 0", ovf, udf); else pass_cnt++;
      total_cnt++; if (mem_wa !== 4'd0 || mem_ra !== 4'd0) $display("FAIL rst_addr got wa=%0d ra=%0d exp 0 0", mem_wa, mem_ra); else pass_cnt++;
      afull_th = 5'd0;
      #1;
      total_cnt++; if (afull !== 1'b1) $display("FAIL rst_afull_th0 got %b exp 1", afull); else pass_cnt++;
      afull_th = 5'd12;
   endtask

   task automatic test_commit();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         fifowr = 1; #1;
         total_cnt++; if (mem_wr !== 1'b1 || mem_wa !== 4'(i)) $display("FAIL cm_wr%0d got wr=%b wa=%0d exp 1 %0d", i, mem_wr, mem_wa, i); else pass_cnt++;
         tick();
      end
      fifowr = 0;
      total_cnt++; if (fifolen !== 5'd5 || rdlen !== 5'd0 || notempty !== 1'b0) $display("FAIL cm_pending got len=%0d rd=%0d ne=%b exp 5 0 0", fifolen, rdlen, notempty); else pass_cnt++;
      total_cnt++; if (mem_rd !== 1'b0) $display("FAIL cm_noread got %b exp 0", mem_rd); else pass_cnt++;
      wr_commit = 1; #1;
      total_cnt++; if (notempty !== 1'b0) $display("FAIL cm_same_cycle got ne=%b exp 0", notempty); else pass_cnt++;
      tick();
      wr_commit = 0;
      total_cnt++; if (rdlen !== 5'd5 || notempty !== 1'b1) $display("FAIL cm_after got rd=%0d ne=%b exp 5 1", rdlen, notempty); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         fiford = 1; #1;
         total_cnt++; if (mem_rd !== 1'b1 || mem_ra !== 4'(i)) $display("FAIL cm_rd%0d got rd=%b ra=%0d exp 1 %0d", i, mem_rd, mem_ra, i); else pass_cnt++;
         tick();
      end
      fiford = 0;
      total_cnt++; if (notempty !== 1'b0 || fifolen !== 5'd0) $display("FAIL cm_drained got ne=%b len=%0d exp 0 0", notempty, fifolen); else pass_cnt++;
   endtask

   task automatic test_discard();
      do_reset();
      fifowr = 1;
      repeat (3) tick();
      fifowr = 0; wr_commit = 1;
      tick();
      wr_commit = 0; fifowr = 1;
      repeat (4) tick();
      total_cnt++; if (fifolen !== 5'd7 || rdlen !== 5'd3) $display("FAIL dc_pre got len=%0d rd=%0d exp 7 3", fifolen, rdlen); else pass_cnt++;
      wr_discard = 1; #1;
      total_cnt++; if (mem_wr !== 1'b0) $display("FAIL dc_suppress got %b exp 0", mem_wr); else pass_cnt++;
      tick();
      wr_discard = 0;
      total_cnt++; if (fifolen !== 5'd3 || rdlen !== 5'd3) $display("FAIL dc_after got len=%0d rd=%0d exp 3 3", fifolen, rdlen); else pass_cnt++;
      #1;
      total_cnt++; if (mem_wr !== 1'b1 || mem_wa !== 4'd3) $display("FAIL dc_next_wa got wr=%b wa=%0d exp 1 3", mem_wr, mem_wa); else pass_cnt++;
      tick();
      fifowr = 0; wr_discard = 1; wr_commit = 1; fiford = 1; #1;
      total_cnt++; if (mem_rd !== 1'b1 || mem_ra !== 4'd0) $display("FAIL dc_read got rd=%b ra=%0d exp 1 0", mem_rd, mem_ra); else pass_cnt++;
      tick();
      clr_in();
      total_cnt++; if (fifolen !== 5'd2 || rdlen !== 5'd2) $display("FAIL dc_commit_ign got len=%0d rd=%0d exp 2 2", fifolen, rdlen); else pass_cnt++;
   endtask

   task automatic test_full();
      do_reset();
      fifowr = 1;
      repeat (15) tick();
      wr_commit = 1;
      tick();
      wr_commit = 0;
      total_cnt++; if (fifofull !== 1'b1 || fifolen !== 5'd16 || rdlen !== 5'd16) $display("FAIL fl_full got f=%b len=%0d rd=%0d exp 1 16 16", fifofull, fifolen, rdlen); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL fl_ovf_pre got %b exp 0", ovf); else pass_cnt++;
      #1;
      total_cnt++; if (mem_wr !== 1'b0) $display("FAIL fl_block got %b exp 0", mem_wr); else pass_cnt++;
      tick();
      total_cnt++; if (ovf !== 1'b1 || fifolen !== 5'd16) $display("FAIL fl_ovf got ovf=%b len=%0d exp 1 16", ovf, fifolen); else pass_cnt++;
      fiford = 1; #1;
      total_cnt++; if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_ra !== 4'd0) $display("FAIL fl_rw_full got wr=%b rd=%b ra=%0d exp 0 1 0", mem_wr, mem_rd, mem_ra); else pass_cnt++;
      tick();
      total_cnt++; if (fifolen !== 5'd15 || mem_wa !== 4'd0 || mem_ra !== 4'd1) $display("FAIL fl_wrap got len=%0d wa=%0d ra=%0d exp 15 0 1", fifolen, mem_wa, mem_ra); else pass_cnt++;
      tick();
      fiford = 0;
      total_cnt++; if (fifolen !== 5'd15 || rdlen !== 5'd14 || mem_wa !== 4'd1) $display("FAIL fl_rw got len=%0d rd=%0d wa=%0d exp 15 14 1", fifolen, rdlen, mem_wa); else pass_cnt++;
      tick();
      total_cnt++; if (fifofull !== 1'b1 || rdlen !== 5'd14) $display("FAIL fl_pend_full got f=%b rd=%0d exp 1 14", fifofull, rdlen); else pass_cnt++;
      err_clr = 1;
      tick();
      fifowr = 0;
      total_cnt++; if (ovf !== 1'b1) $display("FAIL fl_set_wins got %b exp 1", ovf); else pass_cnt++;
      tick();
      err_clr = 0;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL fl_clr got %b exp 0", ovf); else pass_cnt++;
   endtask

   task automatic test_thresholds();
      do_reset();
      afull_th = 5'd12; aempt_th = 5'd2;
      for (int i = 0; i <= 16; i++) begin
         total_cnt++; if (afull !== (i >= 12)) $display("FAIL th_afull lvl=%0d got %b exp %b", i, afull, i >= 12); else pass_cnt++;
         total_cnt++; if (aempty !== (i <= 2)) $display("FAIL th_aempty lvl=%0d got %b exp %b", i, aempty, i <= 2); else pass_cnt++;
         if (i < 16) begin
            fifowr = 1; wr_commit = 1;
            tick();
         end
      end
      clr_in();
   endtask

   task automatic test_flush();
      do_reset();
      fiford = 1;
      tick();
      fiford = 0;
      total_cnt++; if (udf !== 1'b1) $display("FAIL fs_udf_pre got %b exp 1", udf); else pass_cnt++;
      fifowr = 1;
      repeat (2) tick();
      wr_commit = 1;
      tick();
      wr_commit = 0;
      repeat (2) tick();
      fiford = 1; fifoflsh = 1; #1;
      total_cnt++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) $display("FAIL fs_strobe got wr=%b rd=%b exp 0 0", mem_wr, mem_rd); else pass_cnt++;
      tick();
      clr_in();
      total_cnt++; if (fifolen !== 5'd0 || rdlen !== 5'd0 || notempty !== 1'b0) $display("FAIL fs_len got len=%0d rd=%0d ne=%b exp 0 0 0", fifolen, rdlen, notempty); else pass_cnt++;
      total_cnt++; if (udf !== 1'b1 || ovf !== 1'b0) $display("FAIL fs_err got udf=%b ovf=%b exp 1 0", udf, ovf); else pass_cnt++;
      total_cnt++; if (mem_wa !== 4'd0) $display("FAIL fs_wa got %0d exp 0", mem_wa); else pass_cnt++;
      err_clr = 1;
      tick();
      err_clr = 0;
      total_cnt++; if (udf !== 1'b0) $display("FAIL fs_clr1 got %b exp 0", udf); else pass_cnt++;
      fiford = 1;
      tick();
      fiford = 0;
      total_cnt++; if (udf !== 1'b1) $display("FAIL fs_udf_empty got %b exp 1", udf); else pass_cnt++;
      err_clr = 1;
      tick();
      err_clr = 0;
      total_cnt++; if (udf !== 1'b0) $display("FAIL fs_clr2 got %b exp 0", udf); else pass_cnt++;
   endtask

   task automatic test_nopkt();
      do_reset();
      np_wr = 1;
      repeat (3) tick();
      total_cnt++; if (np_fifolen !== 5'd3 || np_rdlen !== 5'd3 || np_notempty !== 1'b1) $display("FAIL np_auto got len=%0d rd=%0d ne=%b exp 3 3 1", np_fifolen, np_rdlen, np_notempty); else pass_cnt++;
      np_discard = 1; #1;
      total_cnt++; if (np_mem_wr !== 1'b1 || np_mem_wa !== 4'd3) $display("FAIL np_disc_ign got wr=%b wa=%0d exp 1 3", np_mem_wr, np_mem_wa); else pass_cnt++;
      tick();
      clr_in();
      total_cnt++; if (np_fifolen !== 5'd4 || np_rdlen !== 5'd4) $display("FAIL np_after got len=%0d rd=%0d exp 4 4", np_fifolen, np_rdlen); else pass_cnt++;
   endtask

`ifdef FIFOFLUSH_PKT_HWM_EN
   task automatic test_hwm();
      do_reset();
      total_cnt++; if (hwm !== 5'd0) $display("FAIL hw_rst got %0d exp 0", hwm); else pass_cnt++;
      fifowr = 1; wr_commit = 1;
      repeat (9) tick();
      fifowr = 0; wr_commit = 0; fiford = 1;
      repeat (9) tick();
      fiford = 0;
      tick();
      total_cnt++; if (hwm !== 5'd9 || fifolen !== 5'd0) $display("FAIL hw_max got hwm=%0d len=%0d exp 9 0", hwm, fifolen); else pass_cnt++;
      fifoflsh = 1;
      tick();
      fifoflsh = 0;
      total_cnt++; if (hwm !== 5'd9) $display("FAIL hw_flush got %0d exp 9", hwm); else pass_cnt++;
      hwm_clr = 1;
      tick();
      hwm_clr = 0;
      total_cnt++; if (hwm !== 5'd0) $display("FAIL hw_clr got %0d exp 0", hwm); else pass_cnt++;
      fifowr = 1;
      tick();
      fifowr = 0; hwm_clr = 1;
      tick();
      hwm_clr = 0;
      total_cnt++; if (hwm !== 5'd1) $display("FAIL hw_clr_max got %0d exp 1", hwm); else pass_cnt++;
   endtask
`endif

   initial begin
      clr_in();
      rst_n = 0;
      afull_th = 5'd12; aempt_th = 5'd2;
      test_reset();
      test_commit();
      test_discard();
      test_full();
      test_thresholds();
      test_flush();
      test_nopkt();
`ifdef FIFOFLUSH_PKT_HWM_EN
      test_hwm();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
